symbol_sequencer: RTL and testbench

Stimulus source that sits directly upstream of the 2-bit-input, 3-bit-output state machines (case, gate-level and ROM variants). It drives their shared input `a`.
- Captures a packed pattern of NSYM 2-bit symbols (for example, a student-ID bit string).
- Emits the symbols MSB-first, each held for a programmable number of clock cycles.
- Supports pause, repeat and a start/busy/done handshake, so benches and top levels stop hand-coding delay chains.

---
 rtl/symbol_sequencer_if.sv | 29 ++
 rtl/symbol_sequencer.sv | 110 +++++++++++
 tb/tb_symbol_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/symbol_sequencer_if.sv
// rtl/symbol_sequencer_if.sv - control and symbol bundle between a stimulus driver and symbol_sequencer
interface symbol_sequencer_if #(
    parameter int NSYM   = 9,
    parameter int HOLD_W = 4,
    parameter int IDX_W  = 4
);
    logic                start;
    logic [2*NSYM-1:0]   pattern;
    logic [HOLD_W-1:0]   hold;
    logic                pause;
    logic                repeat_en;
    logic [1:0]          a;
    logic                valid;
    logic                busy;
    logic                done;
    logic [IDX_W-1:0]    sym_idx;

    // Driver side: issues the run request and the pattern to play
    modport master (
        output start, pattern, hold, pause, repeat_en,
        input  a, valid, busy, done, sym_idx
    );

    // Sequencer side
    modport slave (
        input  start, pattern, hold, pause, repeat_en,
        output a, valid, busy, done, sym_idx
    );
endinterface

// File: rtl/symbol_sequencer.sv
// rtl/symbol_sequencer.sv - plays a packed 2-bit symbol pattern MSB-first with programmable hold, pause and repeat
module symbol_sequencer #(
    parameter int NSYM   = 9,
    parameter int HOLD_W = 4,
    parameter int IDX_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    symbol_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    state_t             state;
    logic [2*NSYM-1:0]  pat_r;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  cnt;
    logic [1:0]         a_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic [IDX_W-1:0]   sym_idx_r;

    // Symbol k sits at the top of the pattern once the pattern is shifted left by 2*k
    function automatic logic [1:0] sym_at(input logic [2*NSYM-1:0] p, input logic [IDX_W-1:0] idx);
        logic [2*NSYM-1:0] sh;
        sh = p << (2 * idx);
        return sh[2*NSYM-1 -: 2];
    endfunction

    // Sequencer FSM: every output is a register updated here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat_r     <= '0;
            hold_r    <= '0;
            cnt       <= '0;
            a_r       <= 2'b00;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sym_idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    a_r     <= 2'b00;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    if (bus.start) begin
                        // Shadow copies make later pattern/hold changes harmless
                        pat_r     <= bus.pattern;
                        hold_r    <= bus.hold;
                        cnt       <= bus.hold;
                        sym_idx_r <= '0;
                        a_r       <= bus.pattern[2*NSYM-1 -: 2];
                        valid_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (sym_idx_r != LAST_IDX) begin
                            sym_idx_r <= sym_idx_r + 1'b1;
                            a_r       <= sym_at(pat_r, sym_idx_r + 1'b1);
                            cnt       <= hold_r;
                        end else if (bus.repeat_en) begin
                            sym_idx_r <= '0;
                            a_r       <= pat_r[2*NSYM-1 -: 2];
                            cnt       <= hold_r;
                        end else begin
                            a_r       <= 2'b00;
                            valid_r   <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            sym_idx_r <= '0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // One-cycle completion pulse; start is not looked at here
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    a_r     <= 2'b00;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.a       = a_r;
    assign bus.valid   = valid_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sym_idx = sym_idx_r;
endmodule

// File: tb/tb_symbol_sequencer.sv
// tb/tb_symbol_sequencer.sv - directed table-driven bench for symbol_sequencer
module tb_symbol_sequencer;
    localparam int NSYM   = 9;
    localparam int HOLD_W = 4;
    localparam int IDX_W  = 4;

    typedef struct {
        logic [17:0]        pattern;
        logic [3:0]         hold;
        logic               disturb;
        logic [0:8][1:0]    syms;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [4];

    symbol_sequencer_if #(.NSYM(NSYM), .HOLD_W(HOLD_W), .IDX_W(IDX_W)) bus ();

    symbol_sequencer #(.NSYM(NSYM), .HOLD_W(HOLD_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a"},     32'(bus.a), 32'd0);
        check({tag, " valid"}, 32'(bus.valid), 32'd0);
        check({tag, " busy"},  32'(bus.busy), 32'd0);
        check({tag, " done"},  32'(bus.done), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{pattern: 18'b01_00_11_00_10_10_00_10_10, hold: 4'd4,  disturb: 1'b0,
                    syms: {2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2}};
        vecs[1] = '{pattern: 18'h3FFFF,                    hold: 4'd0,  disturb: 1'b0,
                    syms: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
        vecs[2] = '{pattern: 18'b00_01_10_11_00_01_10_11_00, hold: 4'd15, disturb: 1'b0,
                    syms: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0}};
        vecs[3] = '{pattern: 18'b11_10_01_00_11_10_01_00_11, hold: 4'd1,  disturb: 1'b1,
                    syms: {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}};

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.pattern   = '0;
        bus.hold      = '0;
        bus.pause     = 1'b0;
        bus.repeat_en = 1'b0;
        step();
        check_idle("reset");
        check("reset sym_idx", 32'(bus.sym_idx), 32'd0);
        reset = 1'b1;
        step();
        check_idle("post-reset");

        // Table-driven full runs
        for (int v = 0; v < 4; v++) begin
            bus.pattern = vecs[v].pattern;
            bus.hold    = vecs[v].hold;
            bus.start   = 1'b1;
            step();
            bus.start   = 1'b0;
            for (int s = 0; s < NSYM; s++) begin
                for (int c = 0; c <= int'(vecs[v].hold); c++) begin
                    string tag;
                    tag = $sformatf("v%0d s%0d c%0d", v, s, c);
                    check({tag, " a"},       32'(bus.a), 32'(vecs[v].syms[s]));
                    check({tag, " valid"},   32'(bus.valid), 32'd1);
                    check({tag, " busy"},    32'(bus.busy), 32'd1);
                    check({tag, " done"},    32'(bus.done), 32'd0);
                    check({tag, " sym_idx"}, 32'(bus.sym_idx), 32'(s));
                    if (vecs[v].disturb) begin
                        bus.start   = 1'b1;
                        bus.pattern = ~vecs[v].pattern;
                        bus.hold    = ~vecs[v].hold;
                    end
                    step();
                end
            end
            check($sformatf("v%0d done pulse", v), 32'(bus.done), 32'd1);
            check($sformatf("v%0d done a", v),     32'(bus.a), 32'd0);
            check($sformatf("v%0d done valid", v), 32'(bus.valid), 32'd0);
            check($sformatf("v%0d done busy", v),  32'(bus.busy), 32'd0);
            step();
            check_idle($sformatf("v%0d after done", v));
            bus.start = 1'b0;
            step();
            check_idle($sformatf("v%0d idle", v));
        end

        // Pause for 3 edges during symbol 2 with hold=1
        begin
            int n_valid;
            int n_sym2;
            int n_done;
            n_valid = 0;
            n_sym2  = 0;
            n_done  = 0;
            bus.pattern = vecs[0].pattern;
            bus.hold    = 4'd1;
            bus.start   = 1'b1;
            step();
            bus.start   = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (bus.valid) n_valid++;
                if (bus.valid && bus.sym_idx == 4'd2) begin
                    n_sym2++;
                    check($sformatf("pause n%0d a", n), 32'(bus.a), 32'd3);
                end
                if (bus.done) n_done++;
                if (n == 4) bus.pause = 1'b1;
                if (n == 7) bus.pause = 1'b0;
                step();
            end
            check("pause run length", 32'(n_valid), 32'd21);
            check("pause sym2 length", 32'(n_sym2), 32'd5);
            check("pause done count", 32'(n_done), 32'd1);
        end

        // Repeat: wraps to symbol 0, then ends after repeat_en drops
        bus.pattern   = vecs[0].pattern;
        bus.hold      = 4'd0;
        bus.repeat_en = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        for (int n = 0; n < 18; n++) begin
            check($sformatf("repeat n%0d sym_idx", n), 32'(bus.sym_idx), 32'(n % 9));
            check($sformatf("repeat n%0d a", n),       32'(bus.a), 32'(vecs[0].syms[n % 9]));
            check($sformatf("repeat n%0d done", n),    32'(bus.done), 32'd0);
            check($sformatf("repeat n%0d valid", n),   32'(bus.valid), 32'd1);
            if (n == 12) bus.repeat_en = 1'b0;
            step();
        end
        check("repeat final done", 32'(bus.done), 32'd1);
        check("repeat final valid", 32'(bus.valid), 32'd0);
        step();
        check_idle("repeat idle");

        // Asynchronous reset in the middle of symbol 4
        bus.hold  = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 13; n++) step();
        check("midrun sym_idx before reset", 32'(bus.sym_idx), 32'd4);
        reset = 1'b0;
        #1;
        check_idle("midrun reset");
        check("midrun reset sym_idx", 32'(bus.sym_idx), 32'd0);
        step();
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check_idle($sformatf("after reset n%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
